// File: rtl/adam_aes_pkg.sv
// adam_aes_pkg: shared key-length, FSM types and key-schedule lookups
package adam_aes_pkg;
  typedef enum logic [1:0] {AES128 = 2'b00, AES192 = 2'b01, AES256 = 2'b10, RSVD = 2'b11} keylen_t;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  function automatic logic [3:0] nk_of(keylen_t k);
    return k == AES256 ? 4'd8 : k == AES192 ? 4'd6 : 4'd4;
  endfunction
  function automatic logic [3:0] nr_of(keylen_t k);
    return k == AES256 ? 4'd14 : k == AES192 ? 4'd12 : 4'd10;
  endfunction
  function automatic logic [7:0] rcon(logic [3:0] r);
    return r <= 4'd8 ? 8'h01 << (r - 4'd1) : r == 4'd9 ? 8'h1b : 8'h36;
  endfunction
endpackage

// File: rtl/adam_aes_key_expansion_multi_if.sv
// adam_aes_key_expansion_multi_if: control, status and round-key read port
interface adam_aes_key_expansion_multi_if;
  logic [255:0] key;
  logic [1:0]   keylen;
  logic         init;
  logic         clear;
  logic         busy;
  logic         ready;
  logic         err;
  logic [3:0]   nr;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  modport master (output key, keylen, init, clear, rk_idx, input busy, ready, err, nr, rk_data);
  modport slave  (input key, keylen, init, clear, rk_idx, output busy, ready, err, nr, rk_data);
endinterface

// File: rtl/adam_aes_subword.sv
// adam_aes_subword: four-byte AES S-box (GF(2^8) inverse plus affine map)
module adam_aes_sbox_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] m);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] p, r;
  always_comb begin
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    y = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  end
endmodule

module adam_aes_subword (
  input  logic [31:0] a,
  output logic [31:0] y
);
  for (genvar g = 0; g < 4; g++) begin : g_sb
    adam_aes_sbox_byte u_sb (.a(a[8*g +: 8]), .y(y[8*g +: 8]));
  end
endmodule

// File: rtl/adam_aes_key_expansion_multi.sv
// adam_aes_key_expansion_multi: iterative AES-128/192/256 key schedule, one word per clock
module adam_aes_key_expansion_multi
  import adam_aes_pkg::*;
#(
  parameter bit SUPPORT_192 = 1'b1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input logic clk,
  input logic reset_n,
  adam_aes_key_expansion_multi_if.slave bus
);
  localparam int MAX_WORDS = SUPPORT_256 ? 60 : SUPPORT_192 ? 52 : 44;
  state_t      state;
  logic [31:0] w [MAX_WORDS];
  logic [5:0]  i, base;
  logic [2:0]  sub;
  logic [3:0]  rnd, nk;
  logic [31:0] prev, sw_in, sw_out, t;
  logic        legal;
  keylen_t     kl;
  adam_aes_subword u_sub (.a(sw_in), .y(sw_out));
  always_comb begin
    kl    = keylen_t'(bus.keylen);
    legal = kl == AES128 || (kl == AES192 && SUPPORT_192) || (kl == AES256 && SUPPORT_256);
    prev  = w[i - 6'd1];
    sw_in = sub == 3'd0 ? {prev[23:0], prev[31:24]} : prev;
    t     = sub == 3'd0 ? sw_out ^ {rcon(rnd), 24'h0} : (nk == 4'd8 && sub == 3'd4) ? sw_out : prev;
    base  = {bus.rk_idx, 2'b00};
    bus.rk_data = bus.rk_idx <= bus.nr ? {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]} : '0;
  end
  // sub tracks i mod Nk and rnd tracks i / Nk, so no divider is needed
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      {i, sub, rnd, nk} <= '0;
      {bus.busy, bus.ready, bus.err, bus.nr} <= '0;
      for (int j = 0; j < MAX_WORDS; j++) w[j] <= '0;
    end else if (bus.clear) begin
      state <= IDLE;
      {i, sub, rnd, nk} <= '0;
      {bus.busy, bus.ready, bus.err, bus.nr} <= '0;
      for (int j = 0; j < MAX_WORDS; j++) w[j] <= '0;
    end else begin
      bus.err <= 1'b0;
      unique case (state)
        IDLE: if (bus.init) begin
          if (legal) begin
            for (int j = 0; j < 8; j++) if (4'(j) < nk_of(kl)) w[j] <= bus.key[255 - 32*j -: 32];
            nk        <= nk_of(kl);
            bus.nr    <= nr_of(kl);
            i         <= {2'b00, nk_of(kl)};
            sub       <= 3'd0;
            rnd       <= 4'd1;
            bus.busy  <= 1'b1;
            bus.ready <= 1'b0;
            state     <= EXPAND;
          end else bus.err <= 1'b1;
        end
        EXPAND: begin
          w[i] <= w[i - {2'b00, nk}] ^ t;
          i    <= i + 6'd1;
          sub  <= sub == nk[2:0] - 3'd1 ? 3'd0 : sub + 3'd1;
          rnd  <= sub == nk[2:0] - 3'd1 ? rnd + 4'd1 : rnd;
          if (i == {bus.nr, 2'b00} + 6'd3) state <= DONE;
        end
        DONE: begin
          bus.busy  <= 1'b0;
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adam_aes_key_expansion_multi.sv
// tb_adam_aes_key_expansion_multi: random and FIPS-197 vectors against a behavioural key-schedule model
module tb_adam_aes_key_expansion_multi;
  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic clk = 1'b0, reset_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [7:0]  sb [256];
  logic [7:0]  rc [11];
  logic [31:0] mw [64];
  logic [127:0] d;
  adam_aes_key_expansion_multi_if b ();
  adam_aes_key_expansion_multi_if b2 ();
  adam_aes_key_expansion_multi dut (.clk(clk), .reset_n(reset_n), .bus(b.slave));
  adam_aes_key_expansion_multi #(.SUPPORT_256(1'b0)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] m);
    logic [15:0] p = 16'h0;
    for (int k = 0; k < 8; k++) if (m[k]) p = p ^ (16'(a) << k);
    for (int k = 15; k >= 8; k--) if (p[k]) p = p ^ (16'h11b << (k - 8));
    return p[7:0];
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction
  task automatic model(input logic [255:0] k, input int nk);
    logic [31:0] t;
    for (int j = 0; j < nk; j++) mw[j] = k[255 - 32*j -: 32];
    for (int j = nk; j < 4 * (nk + 7); j++) begin
      t = mw[j-1];
      if (j % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rc[j/nk], 24'h0};
      else if (nk == 8 && j % 8 == 4) t = subw(t);
      mw[j] = mw[j-nk] ^ t;
    end
  endtask
  task automatic rk(input logic [3:0] idx, output logic [127:0] v);
    @(negedge clk);
    b.rk_idx = idx;
    #1 v = b.rk_data;
  endtask
  task automatic run(input logic [255:0] k, input logic [1:0] kl, input int ign);
    int nk = kl == 2'd2 ? 8 : kl == 2'd1 ? 6 : 4;
    int lat = 0;
    model(k, nk);
    @(negedge clk);
    b.key = k; b.keylen = kl; b.init = 1'b1;
    @(negedge clk);
    b.init = 1'b0;
    while (!b.ready && lat < 100) begin
      b.init = (lat == ign);
      if (lat == ign) b.key = ~k;
      if (lat == ign + 1) check("busy_init_err", b.err, 0);
      @(negedge clk);
      lat++;
    end
    b.init = 1'b0;
    check("latency", lat, nk == 4 ? 41 : nk == 6 ? 47 : 53);
    check("nr", b.nr, nk + 6);
    check("busy_done", b.busy, 0);
    for (int r = 0; r < 16; r++) begin
      rk(4'(r), d);
      check($sformatf("rk%0d", r), d, r <= nk + 6 ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'h0);
    end
  endtask
  initial begin
    logic [7:0] inv, s, c;
    logic [255:0] k;
    int lat;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int q = 0; q < 8; q++)
        s[q] = inv[q] ^ inv[(q+4)%8] ^ inv[(q+5)%8] ^ inv[(q+6)%8] ^ inv[(q+7)%8] ^ c[q];
      sb[x] = s;
    end
    rc[0] = 8'h0; rc[1] = 8'h01;
    for (int r = 2; r < 11; r++) rc[r] = gm(rc[r-1], 8'h02);
    {b.key, b.keylen, b.init, b.clear, b.rk_idx} = '0;
    {b2.key, b2.keylen, b2.init, b2.clear, b2.rk_idx} = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", b.busy, 0);
    check("rst_ready", b.ready, 0);
    check("rst_err", b.err, 0);
    check("rst_nr", b.nr, 0);
    reset_n = 1'b1;
    run(K128, 2'd0, -1);
    rk(4'd1, d);  check("v128_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    rk(4'd10, d); check("v128_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(negedge clk);
    b.keylen = 2'd3; b.init = 1'b1;
    @(negedge clk);
    b.init = 1'b0;
    check("rsvd_err", b.err, 1);
    check("rsvd_ready", b.ready, 1);
    check("rsvd_busy", b.busy, 0);
    @(negedge clk);
    check("rsvd_err_once", b.err, 0);
    rk(4'd10, d); check("rsvd_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(K192, 2'd1, -1);
    rk(4'd12, d); check("v192_w51", d[31:0], 32'h01002202);
    run(K256, 2'd2, -1);
    rk(4'd14, d); check("v256_w59", d[31:0], 32'h706c631e);
    rk(4'd15, d); check("v256_rk15", d, 0);
    for (int n = 0; n < 6; n++) begin
      for (int q = 0; q < 8; q++) k = {k[223:0], 32'($urandom())};
      run(k, 2'(n % 3), n == 4 ? 10 : -1);
    end
    @(negedge clk);
    b.key = K256; b.keylen = 2'd2; b.init = 1'b1;
    @(negedge clk);
    b.init = 1'b0;
    repeat (19) @(negedge clk);
    b.clear = 1'b1;
    @(negedge clk);
    b.clear = 1'b0; b.rk_idx = 4'd0;
    #1;
    check("clr_busy", b.busy, 0);
    check("clr_ready", b.ready, 0);
    check("clr_nr", b.nr, 0);
    check("clr_rk", b.rk_data, 0);
    @(negedge clk);
    b.key = K128; b.keylen = 2'd0; b.init = 1'b1; b.clear = 1'b1;
    @(negedge clk);
    b.init = 1'b0; b.clear = 1'b0;
    check("clrinit_busy", b.busy, 0);
    check("clrinit_nr", b.nr, 0);
    @(negedge clk);
    b.init = 1'b1;
    @(negedge clk);
    b.init = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", b.busy, 0);
    check("arst_nr", b.nr, 0);
    check("arst_rk", b.rk_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run(K128, 2'd0, -1);
    rk(4'd10, d); check("arst_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    model(K128, 4);
    @(negedge clk);
    b2.key = K128; b2.keylen = 2'd0; b2.init = 1'b1;
    @(negedge clk);
    b2.init = 1'b0;
    lat = 0;
    while (!b2.ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("n256_latency", lat, 41);
    b2.keylen = 2'd2; b2.init = 1'b1;
    @(negedge clk);
    b2.init = 1'b0; b2.rk_idx = 4'd10;
    #1;
    check("n256_err", b2.err, 1);
    check("n256_ready", b2.ready, 1);
    check("n256_nr", b2.nr, 10);
    check("n256_rk10", b2.rk_data, {mw[40], mw[41], mw[42], mw[43]});
    @(negedge clk);
    check("n256_err_once", b2.err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
